// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-enable divider bank.
//   mode_e        : channel mode (periodic / one-shot)
//   DEFAULT_CNT_W : default counter and divisor width
//   ch_w()        : channel-select width for a given channel count (minimum 1)
package clk_div_pkg;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  localparam int DEFAULT_CNT_W = 27;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: programmable divisor and mode, tick strobe and toggle wave.
//   clk       : reference clock
//   i_rst_n   : synchronous active-low reset
//   i_en      : run enable; low freezes cnt/done/tog and forces tick low
//   i_restart : restart in phase (cnt/done/tog/tick cleared, div/mode kept)
//   i_load    : take i_div/i_mode and restart counting (tog kept)
//   i_div     : divisor to load
//   i_mode    : mode to load
//   o_tick    : one-cycle strobe at the end of each period
//   o_tog     : inverts on every tick
//   o_active  : divisor non-zero and one-shot not yet finished
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int               CNT_W     = DEFAULT_CNT_W,
  parameter logic [CNT_W-1:0] INIT_DIV  = '0,
  parameter logic             INIT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_restart,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_mode,
  output logic             o_tick,
  output logic             o_tog,
  output logic             o_active
);

  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  mode_e            r_mode;
  logic             r_done;
  logic             r_tick;
  logic             r_tog;
  logic             w_wrap;

  assign w_wrap = (r_cnt == (r_div - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_div  <= INIT_DIV;
      r_mode <= mode_e'(INIT_MODE);
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_tick <= 1'b0;
      r_tog  <= 1'b0;
    end else if (i_restart || i_load) begin
      // A load and a restart in the same cycle both take effect.
      if (i_load) begin
        r_div  <= i_div;
        r_mode <= mode_e'(i_mode);
      end
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_tick <= 1'b0;
      if (i_restart) r_tog <= 1'b0;
    end else if (!i_en) begin
      r_tick <= 1'b0;
    end else if ((r_div == '0) || r_done) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
      r_tog  <= ~r_tog;
      if (r_mode == MODE_ONESHOT) r_done <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_tick   = r_tick;
  assign o_tog    = r_tog;
  assign o_active = (r_div != '0) && !r_done;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel clock-enable generator built from NUM_CH divider channels.
//   clk      : reference clock, all logic on rising edge
//   reset    : synchronous active-low reset
//   en       : global run enable
//   sync     : restart all channels in phase
//   cfg_we   : single-cycle configuration write strobe
//   cfg_ch   : channel addressed by the write
//   cfg_div  : new divisor
//   cfg_mode : new mode (0 periodic, 1 one-shot)
//   cfg_err  : one-cycle pulse after a write to a non-existent channel
//   tick     : per-channel one-cycle period strobe
//   tog      : per-channel square wave, period 2*div
//   active   : per-channel counting indicator
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int                        NUM_CH    = 4,
  parameter int                        CNT_W     = DEFAULT_CNT_W,
  parameter int                        CH_W      = ch_w(NUM_CH),
  parameter logic [NUM_CH*CNT_W-1:0]   INIT_DIV  = {NUM_CH{CNT_W'(25_000_000)}},
  parameter logic [NUM_CH-1:0]         INIT_MODE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] tog,
  output logic [NUM_CH-1:0] active
);

  // One extra bit so NUM_CH itself is representable for the range check.
  localparam logic [CH_W:0] LP_NUM_CH = (CH_W + 1)'(NUM_CH);

  logic [NUM_CH-1:0] w_load;
  logic              w_ch_bad;
  logic              r_cfg_err;

  assign w_ch_bad = ({1'b0, cfg_ch} >= LP_NUM_CH);

  always_ff @(posedge clk) begin
    if (!reset) r_cfg_err <= 1'b0;
    else        r_cfg_err <= cfg_we && w_ch_bad;
  end

  assign cfg_err = r_cfg_err;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_load[c] = cfg_we && (cfg_ch == CH_W'(c));

    clk_div_channel #(
      .CNT_W     (CNT_W),
      .INIT_DIV  (INIT_DIV[c*CNT_W +: CNT_W]),
      .INIT_MODE (INIT_MODE[c])
    ) u_ch (
      .clk       (clk),
      .i_rst_n   (reset),
      .i_en      (en),
      .i_restart (sync),
      .i_load    (w_load[c]),
      .i_div     (cfg_div),
      .i_mode    (cfg_mode),
      .o_tick    (tick[c]),
      .o_tog     (tog[c]),
      .o_active  (active[c])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
module tb_clk_div_bank;

  logic       clk = 1'b0;
  logic       reset, en, sync;
  logic       cfg_we, cfg_we3;
  logic [1:0] cfg_ch, cfg_ch3;
  logic [7:0] cfg_div;
  logic       cfg_mode;
  logic       cfg_err, cfg_err3;
  logic [3:0] tick, tog, active;
  logic [2:0] tick3, tog3, active3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // ch3=5, ch2=3, ch1=1, ch0=0
  clk_div_bank #(
    .NUM_CH   (4),
    .CNT_W    (8),
    .INIT_DIV ({8'd5, 8'd3, 8'd1, 8'd0}),
    .INIT_MODE(4'b0000)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .cfg_err(cfg_err), .tick(tick), .tog(tog), .active(active)
  );

  // ch2=4, ch1=3, ch0=2; channel select is 2 bits so index 3 is out of range
  clk_div_bank #(
    .NUM_CH   (3),
    .CNT_W    (8),
    .INIT_DIV ({8'd4, 8'd3, 8'd2}),
    .INIT_MODE(3'b000)
  ) dut3 (
    .clk(clk), .reset(reset), .en(en), .sync(sync),
    .cfg_we(cfg_we3), .cfg_ch(cfg_ch3), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .cfg_err(cfg_err3), .tick(tick3), .tog(tog3), .active(active3)
  );

  typedef struct {
    logic       we;
    logic [1:0] ch;
    logic [7:0] div;
    logic [3:0] tick;
    logic [3:0] tog;
  } vec_t;

  typedef struct {
    logic       err;
    logic [2:0] tick;
  } vec3_t;

  vec_t  tbl[16];
  vec3_t tbl3[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    // Entry i: outputs expected in cycle i+1, inputs driven during that cycle.
    tbl[0]  = '{1'b0, 2'd0, 8'd0, 4'b0010, 4'b0010};
    tbl[1]  = '{1'b0, 2'd0, 8'd0, 4'b0010, 4'b0000};
    tbl[2]  = '{1'b0, 2'd0, 8'd0, 4'b0110, 4'b0110};
    tbl[3]  = '{1'b0, 2'd0, 8'd0, 4'b0010, 4'b0100};
    tbl[4]  = '{1'b0, 2'd0, 8'd0, 4'b1010, 4'b1110};
    tbl[5]  = '{1'b0, 2'd0, 8'd0, 4'b0110, 4'b1000};
    tbl[6]  = '{1'b1, 2'd2, 8'd4, 4'b0010, 4'b1010};
    tbl[7]  = '{1'b0, 2'd0, 8'd0, 4'b0010, 4'b1000};
    tbl[8]  = '{1'b0, 2'd0, 8'd0, 4'b0010, 4'b1010};
    tbl[9]  = '{1'b0, 2'd0, 8'd0, 4'b1010, 4'b0000};
    tbl[10] = '{1'b0, 2'd0, 8'd0, 4'b0010, 4'b0010};
    tbl[11] = '{1'b0, 2'd0, 8'd0, 4'b0110, 4'b0100};
    tbl[12] = '{1'b0, 2'd0, 8'd0, 4'b0010, 4'b0110};
    tbl[13] = '{1'b0, 2'd0, 8'd0, 4'b0010, 4'b0100};
    tbl[14] = '{1'b0, 2'd0, 8'd0, 4'b1010, 4'b1110};
    tbl[15] = '{1'b0, 2'd0, 8'd0, 4'b0110, 4'b1000};

    // Small bank, cycles 5..8 after reset release (bad write in cycle 3).
    tbl3[0] = '{1'b0, 3'b000};
    tbl3[1] = '{1'b0, 3'b011};
    tbl3[2] = '{1'b0, 3'b000};
    tbl3[3] = '{1'b0, 3'b101};

    reset = 1'b0; en = 1'b1; sync = 1'b0;
    cfg_we = 1'b0; cfg_ch = 2'd0; cfg_we3 = 1'b0; cfg_ch3 = 2'd0;
    cfg_div = 8'd0; cfg_mode = 1'b0;

    repeat (3) @(posedge clk);
    nxt();
    chk("rst_tick", tick, 4'b0000);
    chk("rst_tog", tog, 4'b0000);
    chk("rst_active", active, 4'b1110);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_active3", active3, 3'b111);
    reset = 1'b1;

    // Free-running phase with a divisor rewrite of ch2 in cycle 7.
    for (int i = 0; i < 16; i++) begin
      nxt();
      chk($sformatf("tbl_tick[c%0d]", i + 1), tick, tbl[i].tick);
      chk($sformatf("tbl_tog[c%0d]", i + 1), tog, tbl[i].tog);
      chk($sformatf("tbl_active[c%0d]", i + 1), active, 4'b1110);
      if (i == 7) chk("valid_wr_no_err", cfg_err, 1'b0);
      cfg_we  = tbl[i].we;
      cfg_ch  = tbl[i].ch;
      cfg_div = tbl[i].div;
    end

    // One-shot on ch0 with divisor 2.
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2; cfg_mode = 1'b1;
    nxt();
    cfg_we = 1'b0; cfg_mode = 1'b0;
    chk("os_load_tick", tick[0], 1'b0);
    chk("os_load_active", active[0], 1'b1);
    nxt();
    chk("os_wait_tick", tick[0], 1'b0);
    nxt();
    chk("os_tick", tick[0], 1'b1);
    chk("os_done_active", active[0], 1'b0);
    chk("os_tog", tog[0], 1'b1);
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk("os_after_tick", tick[0], 1'b0);
      chk("os_after_active", active[0], 1'b0);
      chk("os_after_tog", tog[0], 1'b1);
    end

    // Sync re-arms the one-shot and aligns everyone.
    sync = 1'b1;
    nxt();
    sync = 1'b0;
    chk("sync_tick", tick, 4'b0000);
    chk("sync_tog", tog, 4'b0000);
    chk("sync_active", active, 4'b1111);
    nxt();
    chk("sync_c1_tick", tick, 4'b0010);
    nxt();
    chk("sync_c2_tick", tick, 4'b0011);
    chk("sync_c2_active0", active[0], 1'b0);
    chk("sync_c2_tog", tog, 4'b0001);

    // Freeze with ch3 at cnt=2.
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      nxt();
      chk("frz_tick", tick, 4'b0000);
      chk("frz_tog", tog, 4'b0001);
    end
    en = 1'b1;
    nxt();
    chk("resume1_tick", tick, 4'b0010);
    nxt();
    chk("resume2_tick", tick, 4'b0110);
    nxt();
    chk("resume3_tick", tick, 4'b1010);
    chk("resume3_tog", tog, 4'b1111);

    // Sync and write ch1 div=2 together, then reset mid-period.
    sync = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd2; cfg_mode = 1'b0;
    nxt();
    sync = 1'b0; cfg_we = 1'b0;
    chk("sw_tick", tick, 4'b0000);
    chk("sw_tog", tog, 4'b0000);
    chk("sw_active", active, 4'b1111);
    nxt();
    chk("sw_c1_tick", tick, 4'b0000);
    nxt();
    chk("sw_c2_tick", tick, 4'b0011);
    chk("sw_c2_tog", tog, 4'b0011);
    chk("sw_c2_active", active, 4'b1110);

    reset = 1'b0;
    nxt();
    chk("rst2_tick", tick, 4'b0000);
    chk("rst2_tog", tog, 4'b0000);
    chk("rst2_active", active, 4'b1110);
    chk("rst2_cfg_err", cfg_err, 1'b0);
    reset = 1'b1;

    // ch1 back to divisor 1 proves divisors were reinitialised.
    nxt();
    chk("rel_c1_tick", tick, 4'b0010);
    chk("rel_c1_tick3", tick3, 3'b000);
    nxt();
    chk("rel_c2_tick", tick, 4'b0010);
    chk("rel_c2_tick3", tick3, 3'b001);
    nxt();
    chk("rel_c3_tick", tick, 4'b0110);
    chk("rel_c3_tick3", tick3, 3'b010);

    // Out-of-range write on the three-channel bank.
    cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_div = 8'd1; cfg_mode = 1'b1;
    nxt();
    cfg_we3 = 1'b0; cfg_ch3 = 2'd0; cfg_mode = 1'b0;
    chk("bad_wr_err", cfg_err3, 1'b1);
    chk("bad_wr_tick3", tick3, 3'b101);
    chk("bad_wr_other_err", cfg_err, 1'b0);
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk($sformatf("bad_err[c%0d]", i + 5), cfg_err3, tbl3[i].err);
      chk($sformatf("bad_tick3[c%0d]", i + 5), tick3, tbl3[i].tick);
      chk($sformatf("bad_active3[c%0d]", i + 5), active3, 3'b111);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
